// File: rtl/pkt_framer_crc.sv
// Packet framer: echoes a K.28.1 preamble and payload, then appends K.23.7, a little-endian CRC-32 and K.28.5.
// Optional overlength abort (K.30.7 then drop to K.28.5) is compiled in by defining PKT_FRAMER_ABORT_EN.
module pkt_framer_crc #(
   parameter int NUM_SYNC = 4,
   parameter int MAX_LEN  = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pushin,
   input  logic [8:0]  datain,
   input  logic        startin,
   output logic        readyout,
   output logic        pushout,
   output logic [8:0]  dataout,
   output logic        startout,
   output logic        sync_err,
   output logic [15:0] pkt_count
);

   // Out-of-range parameters fall back to their defaults.
   localparam bit PARAMS_OK = (NUM_SYNC >= 1) && (NUM_SYNC <= 8) && (MAX_LEN >= 1) && (MAX_LEN <= 65535);
   localparam logic [3:0] NUM_SYNC_C = PARAMS_OK ? 4'(NUM_SYNC) : 4'd4;
`ifdef PKT_FRAMER_ABORT_EN
   localparam logic [15:0] MAX_LEN_C = PARAMS_OK ? 16'(MAX_LEN) : 16'd1024;
`endif

   localparam logic [8:0]  K28_1    = 9'h13C;
   localparam logic [8:0]  K28_5    = 9'h1BC;
   localparam logic [8:0]  K23_7    = 9'h1F7;
`ifdef PKT_FRAMER_ABORT_EN
   localparam logic [8:0]  K30_7    = 9'h1FE;
`endif
   localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      S_IDLE, S_SYNC, S_DATA, S_MARK, S_CRC, S_EOP
`ifdef PKT_FRAMER_ABORT_EN
      , S_ABORT, S_DROP
`endif
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  sync_cnt_q, sync_cnt_d;
   logic [31:0] crc_q, crc_d;
   logic [1:0]  idx_q, idx_d;
   logic [15:0] pkt_count_q, pkt_count_d;
`ifdef PKT_FRAMER_ABORT_EN
   logic [15:0] len_q, len_d;
`endif
   logic        pushout_q, pushout_d;
   logic [8:0]  dataout_q, dataout_d;
   logic        startout_q, startout_d;
   logic        sync_err_q, sync_err_d;
   logic        readyout_q, readyout_d;

   logic        xfer, start_hit, is_k281, is_k285, is_data, in_pkt, echo;
   logic [31:0] crc_fin;

   // Reflected CRC-32 (poly 0x04C11DB7 reversed), one byte LSB first.
   function automatic logic [31:0] crc_fold(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      end
      return r;
   endfunction

   assign xfer      = pushin && readyout_q;
   assign is_k281   = (datain == K28_1);
   assign is_k285   = (datain == K28_5);
   assign is_data   = ~datain[8];
   assign start_hit = xfer && is_k281 && startin;
   assign in_pkt    = (state_q == S_SYNC) || (state_q == S_DATA);
   assign crc_fin   = ~crc_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         sync_cnt_q  <= 4'd0;
         crc_q       <= CRC_INIT;
         idx_q       <= 2'd0;
         pkt_count_q <= 16'd0;
`ifdef PKT_FRAMER_ABORT_EN
         len_q       <= 16'd0;
`endif
         pushout_q   <= 1'b0;
         dataout_q   <= 9'h000;
         startout_q  <= 1'b0;
         sync_err_q  <= 1'b0;
         readyout_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_cnt_q  <= sync_cnt_d;
         crc_q       <= crc_d;
         idx_q       <= idx_d;
         pkt_count_q <= pkt_count_d;
`ifdef PKT_FRAMER_ABORT_EN
         len_q       <= len_d;
`endif
         pushout_q   <= pushout_d;
         dataout_q   <= dataout_d;
         startout_q  <= startout_d;
         sync_err_q  <= sync_err_d;
         readyout_q  <= readyout_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sync_cnt_d  = sync_cnt_q;
      crc_d       = crc_q;
      idx_d       = idx_q;
      pkt_count_d = pkt_count_q;
`ifdef PKT_FRAMER_ABORT_EN
      len_d       = len_q;
`endif
      case (state_q)
         S_IDLE, S_SYNC, S_DATA: begin
            // A flagged K.28.1 always (re)opens a packet, abandoning any in progress.
            if (start_hit) begin
               state_d    = S_SYNC;
               sync_cnt_d = 4'd1;
               crc_d      = CRC_INIT;
            end else if (xfer && state_q == S_SYNC) begin
               if (is_k281) begin
                  if (sync_cnt_q < NUM_SYNC_C) sync_cnt_d = sync_cnt_q + 4'd1;
               end else if (sync_cnt_q < NUM_SYNC_C) begin
                  state_d    = S_IDLE;
                  sync_cnt_d = 4'd0;
                  crc_d      = CRC_INIT;
               end else if (is_data) begin
                  state_d = S_DATA;
                  crc_d   = crc_fold(crc_q, datain[7:0]);
`ifdef PKT_FRAMER_ABORT_EN
                  len_d   = 16'd1;
`endif
               end else if (is_k285) begin
                  state_d = S_MARK;
               end
            end else if (xfer && state_q == S_DATA) begin
               if (is_data) begin
`ifdef PKT_FRAMER_ABORT_EN
                  if (len_q == MAX_LEN_C) begin
                     state_d = S_ABORT;
                  end else begin
                     crc_d = crc_fold(crc_q, datain[7:0]);
                     len_d = len_q + 16'd1;
                  end
`else
                  crc_d = crc_fold(crc_q, datain[7:0]);
`endif
               end else if (is_k285) begin
                  state_d = S_MARK;
               end
            end
         end
         S_MARK: begin
            state_d = S_CRC;
            idx_d   = 2'd0;
         end
         S_CRC: begin
            if (idx_q == 2'd3) begin
               state_d     = S_EOP;
               pkt_count_d = pkt_count_q + 16'd1;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
         S_EOP: begin
            state_d    = S_IDLE;
            sync_cnt_d = 4'd0;
            crc_d      = CRC_INIT;
         end
`ifdef PKT_FRAMER_ABORT_EN
         S_ABORT, S_DROP: begin
            if (xfer && is_k285) begin
               state_d    = S_IDLE;
               sync_cnt_d = 4'd0;
               crc_d      = CRC_INIT;
            end else begin
               state_d = S_DROP;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are registered, so they are derived from the state being entered.
   always_comb begin
      pushout_d  = 1'b0;
      dataout_d  = 9'h000;
      startout_d = 1'b0;
      sync_err_d = 1'b0;
      readyout_d = 1'b1;
      echo       = xfer && (in_pkt || state_q == S_IDLE) && (state_d == S_SYNC || state_d == S_DATA);
      case (state_d)
         S_MARK: begin
            pushout_d  = 1'b1;
            dataout_d  = K23_7;
            readyout_d = 1'b0;
         end
         S_CRC: begin
            pushout_d  = 1'b1;
            dataout_d  = {1'b0, crc_fin[{idx_d, 3'b000} +: 8]};
            readyout_d = 1'b0;
         end
         S_EOP: begin
            pushout_d  = 1'b1;
            dataout_d  = K28_5;
            readyout_d = 1'b0;
         end
`ifdef PKT_FRAMER_ABORT_EN
         S_ABORT: begin
            pushout_d = 1'b1;
            dataout_d = K30_7;
         end
`endif
         default: ;
      endcase
      if (echo) begin
         pushout_d = 1'b1;
         dataout_d = datain;
      end
      startout_d = echo && start_hit;
      sync_err_d = xfer && ((in_pkt && start_hit) || (state_q == S_SYNC && state_d == S_IDLE));
   end

   assign readyout  = readyout_q;
   assign pushout   = pushout_q;
   assign dataout   = dataout_q;
   assign startout  = startout_q;
   assign sync_err  = sync_err_q;
   assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_pkt_framer_crc.sv
// Scoreboard bench for pkt_framer_crc: a packet-level reference model queues expected symbols,
// a monitor pops them whenever pushout is high.
module tb_pkt_framer_crc;

   localparam int NUM_SYNC = 4;
   localparam logic [8:0] K28_1 = 9'h13C;
   localparam logic [8:0] K28_3 = 9'h17C;
   localparam logic [8:0] K28_5 = 9'h1BC;
   localparam logic [8:0] K23_7 = 9'h1F7;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        pushin = 1'b0;
   logic [8:0]  datain = 9'h000;
   logic        startin = 1'b0;
   logic        readyout, pushout, startout, sync_err;
   logic [8:0]  dataout;
   logic [15:0] pkt_count;

   pkt_framer_crc #(.NUM_SYNC(NUM_SYNC), .MAX_LEN(1024)) dut (
      .clk       (clk),
      .reset     (reset),
      .pushin    (pushin),
      .datain    (datain),
      .startin   (startin),
      .readyout  (readyout),
      .pushout   (pushout),
      .dataout   (dataout),
      .startout  (startout),
      .sync_err  (sync_err),
      .pkt_count (pkt_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [8:0]  d;
      logic        st;
      logic        chk;
      logic [15:0] cnt;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          exp_serr = 0;
   int          got_serr = 0;
   logic [15:0] model_pkts = 16'd0;
   bit          skip_run = 1'b1;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endfunction

   // Reference CRC: non-reflected MSB-first engine on bit-reversed bytes, result reversed and inverted.
   function automatic logic [31:0] ref_crc(input logic [7:0] bytes[$]);
      logic [31:0] c;
      logic [31:0] r;
      logic [7:0]  rb;
      c = 32'hFFFF_FFFF;
      foreach (bytes[i]) begin
         for (int j = 0; j < 8; j++) rb[j] = bytes[i][7-j];
         c = c ^ {rb, 24'h0};
         for (int j = 0; j < 8; j++) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
      end
      for (int j = 0; j < 32; j++) r[j] = c[31-j];
      return ~r;
   endfunction

   function automatic void expect_sym(input logic [8:0] d, input logic st);
      exp_t e;
      e.d = d; e.st = st; e.chk = 1'b0; e.cnt = 16'd0;
      exp_q.push_back(e);
   endfunction

   function automatic void expect_eop();
      exp_t e;
      model_pkts = model_pkts + 16'd1;
      e.d = K28_5; e.st = 1'b0; e.chk = 1'b1; e.cnt = model_pkts;
      exp_q.push_back(e);
   endfunction

   // Called at a negedge; returns at the negedge after the symbol was accepted.
   task automatic send(input logic [8:0] sym, input logic st);
      int guard;
      guard = 0;
      pushin = 1'b1; datain = sym; startin = st;
      while (readyout !== 1'b1 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 40) begin
         n_checks++; n_fail++;
         $display("FAIL readyout_timeout: readyout %b, required 1", readyout);
      end
      @(negedge clk);
      pushin = 1'b0; startin = 1'b0;
   endtask

   task automatic gap(input int n);
      pushin = 1'b0; startin = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic good_pkt(input int nsync, input logic [8:0] body[$], input int maxgap);
      logic [7:0]  bytes[$];
      logic [31:0] crc;
      for (int i = 0; i < nsync; i++) begin
         expect_sym(K28_1, i == 0);
         send(K28_1, i == 0);
         gap($urandom_range(0, maxgap));
      end
      foreach (body[i]) begin
         expect_sym(body[i], 1'b0);
         if (!body[i][8]) bytes.push_back(body[i][7:0]);
         send(body[i], 1'b0);
         gap($urandom_range(0, maxgap));
      end
      crc = ref_crc(bytes);
      expect_sym(K23_7, 1'b0);
      for (int b = 0; b < 4; b++) expect_sym({1'b0, crc[8*b +: 8]}, 1'b0);
      expect_eop();
      send(K28_5, 1'b0);
   endtask

   task automatic rand_good(input int maxgap);
      logic [8:0] body[$];
      int len;
      len = $urandom_range(1, 16);
      body.push_back({1'b0, 8'($urandom)});
      for (int i = 1; i < len; i++) begin
         if ($urandom_range(0, 9) == 0) body.push_back(($urandom_range(0, 1) == 1) ? K28_1 : K28_3);
         else body.push_back({1'b0, 8'($urandom)});
      end
      good_pkt($urandom_range(NUM_SYNC, NUM_SYNC + 2), body, maxgap);
   endtask

   task automatic bad_preamble();
      int k;
      logic [8:0] bad;
      k = $urandom_range(1, NUM_SYNC - 1);
      for (int i = 0; i < k; i++) begin
         expect_sym(K28_1, i == 0);
         send(K28_1, i == 0);
      end
      case ($urandom_range(0, 2))
         0: bad = K28_5;
         1: bad = K28_3;
         default: bad = {1'b0, 8'($urandom)};
      endcase
      exp_serr++;
      send(bad, 1'b0);
   endtask

   // Partial packet cut short by a new flagged K.28.1; the caller sends that new packet.
   task automatic abandon_prefix();
      int k;
      int m;
      logic [8:0] sym;
      k = $urandom_range(1, NUM_SYNC + 2);
      m = (k >= NUM_SYNC) ? $urandom_range(0, 3) : 0;
      for (int i = 0; i < k; i++) begin
         expect_sym(K28_1, i == 0);
         send(K28_1, i == 0);
      end
      for (int i = 0; i < m; i++) begin
         sym = {1'b0, 8'($urandom)};
         expect_sym(sym, 1'b0);
         send(sym, 1'b0);
      end
      exp_serr++;
   endtask

   task automatic idle_garbage();
      int n;
      logic [8:0] sym;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 2))
            0: send(K28_1, 1'b0);
            1: send(K28_5, $urandom_range(0, 1) == 1);
            default: begin
               sym = {1'b0, 8'($urandom)};
               send(sym, $urandom_range(0, 1) == 1);
            end
         endcase
      end
   endtask

   // Monitor: scoreboard pops, sync_err pulse count, readyout low-run length.
   initial begin
      int low_run;
      exp_t e;
      low_run = 0;
      forever begin
         @(negedge clk);
         if (sync_err === 1'b1) got_serr++;
         if (pushout === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL spurious_output: dataout %h, required no output", dataout);
            end else begin
               e = exp_q.pop_front();
               check("dataout", 32'(dataout), 32'(e.d));
               check("startout", 32'(startout), 32'(e.st));
               if (e.chk) check("pkt_count_at_eop", 32'(pkt_count), 32'(e.cnt));
            end
         end
         if (readyout !== 1'b1) begin
            low_run++;
         end else begin
            if (low_run > 0) begin
               if (skip_run) skip_run = 1'b0;
               else check("ready_low_cycles", low_run, 6);
            end
            low_run = 0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation time exhausted, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [8:0] body[$];
      repeat (3) @(negedge clk);
      check("rst_pushout", 32'(pushout), 0);
      check("rst_dataout", 32'(dataout), 0);
      check("rst_startout", 32'(startout), 0);
      check("rst_sync_err", 32'(sync_err), 0);
      check("rst_readyout", 32'(readyout), 0);
      check("rst_pkt_count", 32'(pkt_count), 0);
      reset = 1'b1;
      @(negedge clk);
      check("ready_after_reset", 32'(readyout), 1);

      // Known-answer packet: "123456789" -> CRC 0xCBF43926.
      for (int i = 0; i < 4; i++) begin
         expect_sym(K28_1, i == 0);
         send(K28_1, i == 0);
      end
      for (int i = 0; i < 9; i++) begin
         expect_sym({1'b0, 8'(8'h31 + i)}, 1'b0);
         send({1'b0, 8'(8'h31 + i)}, 1'b0);
      end
      expect_sym(9'h1F7, 1'b0);
      expect_sym(9'h026, 1'b0);
      expect_sym(9'h039, 1'b0);
      expect_sym(9'h0F4, 1'b0);
      expect_sym(9'h0CB, 1'b0);
      expect_eop();
      send(K28_5, 1'b0);

      // Short preamble, sent back-to-back while readyout is low.
      for (int i = 0; i < 3; i++) begin
         expect_sym(K28_1, i == 0);
         send(K28_1, i == 0);
      end
      exp_serr++;
      send(9'h055, 1'b0);
      gap(3);
      check("sync_err_short_preamble", got_serr, exp_serr);
      check("pkt_count_after_bad", 32'(pkt_count), 32'(model_pkts));

      for (int it = 0; it < 80; it++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: rand_good(2);
            5, 6: bad_preamble();
            7: begin abandon_prefix(); rand_good(1); end
            8: idle_garbage();
            default: rand_good(0);
         endcase
         gap($urandom_range(0, 2));
      end

      // Reset while the second CRC byte is on dataout.
      body.delete();
      for (int i = 0; i < 5; i++) body.push_back({1'b0, 8'($urandom)});
      good_pkt(NUM_SYNC, body, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      skip_run = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      model_pkts = 16'd0;
      repeat (3) @(negedge clk);
      check("midcrc_rst_pushout", 32'(pushout), 0);
      check("midcrc_rst_pkt_count", 32'(pkt_count), 0);
      reset = 1'b1;
      @(negedge clk);
      for (int it = 0; it < 4; it++) rand_good(1);

      gap(20);
      check("queue_drained", exp_q.size(), 0);
      check("sync_err_total", got_serr, exp_serr);
      check("pkt_count_final", 32'(pkt_count), 32'(model_pkts));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
